// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: FSM encoding and default widths.
package pc_fetch_unit_pkg;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned INSTR_W_DEF = 16;

    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SQUASH = 2'd3
    } fetch_state_t;

endpackage : pc_fetch_unit_pkg

// File: rtl/pc_fetch_unit_mux2to1.sv
// Single-bit 2:1 selector; one instance per next-PC bit.
module mux2to1 (
    input  logic hyrja0,
    input  logic hyrja1,
    input  logic selektori,
    output logic dalja
);

    assign dalja = selektori ? hyrja1 : hyrja0;

endmodule : mux2to1

// File: rtl/pc_fetch_unit.sv
// PC and instruction-fetch stage: one outstanding imem request, one-entry
// instruction buffer toward decode, redirect squashes in-flight work.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned       PC_STEP  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               halt,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] squash_addr;
    logic              accept_c;
    logic              pc_load_c;
    fetch_state_t      resume_c;

    assign pc_inc    = pc + ADDR_W'(PC_STEP);
    assign accept_c  = (state == ST_REQ) && imem_ack && !redirect;
    assign pc_load_c = redirect || accept_c;
    assign resume_c  = halt ? ST_IDLE : ST_REQ;

    // Next-PC select: sequential increment vs branch target
    for (genvar i = 0; i < int'(ADDR_W); i++) begin : g_next_pc
        mux2to1 u_mux (
            .hyrja0    (pc_inc[i]),
            .hyrja1    (redirect_addr[i]),
            .selektori (redirect),
            .dalja     (next_pc[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Redirect wins in every state; SQUASH waits out the abandoned request
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                state_next = resume_c;
            end
            ST_REQ: begin
                if (redirect && !imem_ack) begin
                    state_next = ST_SQUASH;
                end else if (redirect) begin
                    state_next = resume_c;
                end else if (imem_ack) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect || instr_ready) begin
                    state_next = resume_c;
                end
            end
            ST_SQUASH: begin
                if (!redirect && imem_ack) begin
                    state_next = resume_c;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        imem_addr   = pc;
        case (state)
            ST_REQ: begin
                imem_req = 1'b1;
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
            end
            ST_SQUASH: begin
                imem_req  = 1'b1;
                imem_addr = squash_addr;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    // PC, frozen request address and instruction buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            squash_addr <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            if (pc_load_c) begin
                pc <= next_pc;
            end
            if ((state == ST_REQ) && redirect && !imem_ack) begin
                squash_addr <= pc;
            end
            if (accept_c) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
        end
    end

endmodule : pc_fetch_unit
